pc_sequencer: RTL and testbench

Fetch controller that owns the 16-bit program counter and sequences the PC incrementor and instruction memory. It issues one instruction-memory request at a time and presents the returned word to decode through a valid/ready handshake. It also applies branch/jump redirects and stops fetching on halt. It sits between the core control unit and the instruction memory port.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/incrementor.sv | 11 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-sequencer state encoding, PC width and the
// default reset vector.
package cpu_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_VEC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } pc_seq_state_t;

endpackage

// File: rtl/incrementor.sv
// Modulo-2^W incrementor; wraps silently from all-ones to zero.
module incrementor #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a + W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a time and hands
// the returned word to decode over a valid/ready handshake.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            ir_valid,
    output logic [PC_W-1:0] ir,
    output logic [PC_W-1:0] ir_pc,
    input  logic            ir_ready,
    output logic            halted
);

    pc_seq_state_t   state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] ir_reg, ir_next;
    logic [PC_W-1:0] ir_pc_reg, ir_pc_next;
    logic            squash_reg, squash_next;
    logic            req_prev_reg;
    logic [PC_W-1:0] pc_inc;

    incrementor #(.W(PC_W)) u_incr (
        .a (pc_reg),
        .y (pc_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_VEC;
            ir_reg       <= '0;
            ir_pc_reg    <= '0;
            squash_reg   <= 1'b0;
            req_prev_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
            ir_pc_reg    <= ir_pc_next;
            squash_reg   <= squash_next;
            req_prev_reg <= (state_reg == FETCH);
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        ir_pc_next  = ir_pc_reg;
        squash_next = squash_reg;

        if (halt) begin
            state_next  = HALT;
            squash_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (redirect_valid) pc_next = redirect_pc;
                    if (en) state_next = FETCH;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc_next = redirect_pc;
                        // A request already seen by memory will still return the old word.
                        squash_next = imem_ack ? 1'b0 : (squash_reg | req_prev_reg);
                    end else if (imem_ack) begin
                        if (squash_reg) begin
                            squash_next = 1'b0;
                        end else begin
                            ir_next    = imem_rdata;
                            ir_pc_next = pc_reg;
                            pc_next    = pc_inc;
                            state_next = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (redirect_valid) begin
                        pc_next    = redirect_pc;
                        state_next = FETCH;
                    end else if (ir_ready) begin
                        state_next = en ? FETCH : IDLE;
                    end
                end
                HALT: ;
                default: state_next = IDLE;
            endcase
        end
    end

    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign ir_valid  = (state_reg == ISSUE);
    assign ir        = ir_reg;
    assign ir_pc     = ir_pc_reg;
    assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the memory side is driven by hand, cycle by cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_ready       (ir_ready),
        .halted         (halted)
    );

    // Flags are compared as {imem_req, ir_valid, halted}.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0; imem_ack = 1'b0; imem_rdata = 16'h0; ir_ready = 1'b0;
        step();
        if ({imem_req, ir_valid, halted} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {imem_req, ir_valid, halted}); n_bad++;
        end
        n_cmp++;
        if ({imem_addr, ir, ir_pc} !== 48'h0) begin
            $display("FAIL reset_regs: addr=%h ir=%h ir_pc=%h want all 0000", imem_addr, ir, ir_pc); n_bad++;
        end
        n_cmp++;
        rst_n = 1'b1;
        step();
        if ({imem_req, ir_valid, halted} !== 3'b000) begin
            $display("FAIL idle_no_en: got %b want 000", {imem_req, ir_valid, halted}); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_zero_wait();
        en = 1'b1;
        step();
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'h0000}) begin
            $display("FAIL zw_fetch: flags=%b addr=%h want 100/0000", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        imem_ack = 1'b1; imem_rdata = 16'hA001;
        step();
        imem_ack = 1'b0;
        if ({imem_req, ir_valid, halted, ir, ir_pc} !== {3'b010, 16'hA001, 16'h0000}) begin
            $display("FAIL zw_issue: flags=%b ir=%h ir_pc=%h want 010/A001/0000",
                     {imem_req, ir_valid, halted}, ir, ir_pc); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            if ({imem_req, ir_valid, halted, ir, ir_pc} !== {3'b010, 16'hA001, 16'h0000}) begin
                $display("FAIL stall_%0d: flags=%b ir=%h ir_pc=%h want 010/A001/0000",
                         i, {imem_req, ir_valid, halted}, ir, ir_pc); n_bad++;
            end
            n_cmp++;
        end
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'h0001}) begin
            $display("FAIL stall_release: flags=%b addr=%h want 100/0001", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 16'h0001 + 16'(k);
            imem_ack = 1'b1; imem_rdata = 16'hB000 + 16'(k);
            step();
            imem_ack = 1'b0;
            if ({imem_req, ir_valid, ir, ir_pc} !== {2'b01, 16'hB000 + 16'(k), a}) begin
                $display("FAIL b2b_issue_%0d: req=%b valid=%b ir=%h ir_pc=%h want 0/1/%h/%h",
                         k, imem_req, ir_valid, ir, ir_pc, 16'hB000 + 16'(k), a); n_bad++;
            end
            n_cmp++;
            ir_ready = 1'b1;
            step();
            ir_ready = 1'b0;
            if ({imem_req, ir_valid, imem_addr} !== {2'b10, a + 16'h0001}) begin
                $display("FAIL b2b_fetch_%0d: req=%b valid=%b addr=%h want 1/0/%h",
                         k, imem_req, ir_valid, imem_addr, a + 16'h0001); n_bad++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_redirect_ready();
        imem_ack = 1'b1; imem_rdata = 16'hC003;
        step();
        imem_ack = 1'b0;
        if ({ir_valid, ir_pc} !== {1'b1, 16'h0003}) begin
            $display("FAIL rr_issue: valid=%b ir_pc=%h want 1/0003", ir_valid, ir_pc); n_bad++;
        end
        n_cmp++;
        redirect_valid = 1'b1; redirect_pc = 16'hFFFF; ir_ready = 1'b1;
        step();
        redirect_valid = 1'b0; ir_ready = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'hFFFF}) begin
            $display("FAIL rr_target: flags=%b addr=%h want 100/FFFF", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        imem_ack = 1'b0;
        if ({ir_valid, ir, ir_pc} !== {1'b1, 16'h1234, 16'hFFFF}) begin
            $display("FAIL wrap_issue: valid=%b ir=%h ir_pc=%h want 1/1234/FFFF", ir_valid, ir, ir_pc); n_bad++;
        end
        n_cmp++;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            $display("FAIL wrap_addr: req=%b addr=%h want 1/0000", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_squash();
        step();
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            $display("FAIL sq_wait: req=%b addr=%h want 1/0000", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'h0040}) begin
            $display("FAIL sq_redirect: flags=%b addr=%h want 100/0040", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        step();
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        step();
        imem_ack = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'h0040}) begin
            $display("FAIL sq_stale_dropped: flags=%b addr=%h want 100/0040", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        imem_ack = 1'b1; imem_rdata = 16'h5555;
        step();
        imem_ack = 1'b0;
        if ({ir_valid, ir, ir_pc} !== {1'b1, 16'h5555, 16'h0040}) begin
            $display("FAIL sq_new_word: valid=%b ir=%h ir_pc=%h want 1/5555/0040", ir_valid, ir, ir_pc); n_bad++;
        end
        n_cmp++;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0041}) begin
            $display("FAIL sq_next: req=%b addr=%h want 1/0041", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 16'hBAD0; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        step();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b100, 16'h0100}) begin
            $display("FAIL ra_discard: flags=%b addr=%h want 100/0100", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        imem_ack = 1'b1; imem_rdata = 16'h7777;
        step();
        imem_ack = 1'b0;
        if ({ir_valid, ir, ir_pc} !== {1'b1, 16'h7777, 16'h0100}) begin
            $display("FAIL ra_word: valid=%b ir=%h ir_pc=%h want 1/7777/0100", ir_valid, ir, ir_pc); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_idle_redirect();
        en = 1'b0; ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b000, 16'h0101}) begin
            $display("FAIL idle_enter: flags=%b addr=%h want 000/0101", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        step();
        redirect_valid = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b000, 16'h0200}) begin
            $display("FAIL idle_redirect: flags=%b addr=%h want 000/0200", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        en = 1'b1;
        step();
        if ({imem_req, imem_addr} !== {1'b1, 16'h0200}) begin
            $display("FAIL idle_resume: req=%b addr=%h want 1/0200", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
    endtask

    task automatic test_halt();
        halt = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h9999; redirect_valid = 1'b1; redirect_pc = 16'h0300;
        step();
        halt = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0;
        if ({imem_req, ir_valid, halted, imem_addr} !== {3'b001, 16'h0200}) begin
            $display("FAIL halt_enter: flags=%b addr=%h want 001/0200", {imem_req, ir_valid, halted}, imem_addr); n_bad++;
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            imem_ack = i[0]; redirect_valid = 1'b1; redirect_pc = 16'h0400; ir_ready = 1'b1;
            step();
            if ({imem_req, ir_valid, halted, imem_addr} !== {3'b001, 16'h0200}) begin
                $display("FAIL halt_hold_%0d: flags=%b addr=%h want 001/0200", i, {imem_req, ir_valid, halted}, imem_addr); n_bad++;
            end
            n_cmp++;
        end
        imem_ack = 1'b0; redirect_valid = 1'b0; ir_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        if ({imem_req, ir_valid, halted} !== 3'b000) begin
            $display("FAIL ar_leave_halt: flags=%b want 000", {imem_req, ir_valid, halted}); n_bad++;
        end
        n_cmp++;
        step();
        rst_n = 1'b1; en = 1'b1;
        step();
        imem_ack = 1'b1; imem_rdata = 16'h1111;
        step();
        imem_ack = 1'b0; ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin
            $display("FAIL ar_prefetch: req=%b addr=%h want 1/0001", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
        #2 imem_ack = 1'b1; imem_rdata = 16'h2222; rst_n = 1'b0;
        #1;
        if ({imem_req, imem_addr} !== {1'b0, 16'h0000}) begin
            $display("FAIL ar_mid_fetch: req=%b addr=%h want 0/0000", imem_req, imem_addr); n_bad++;
        end
        n_cmp++;
        step();
        if ({imem_req, ir_valid, halted, ir} !== {3'b000, 16'h0000}) begin
            $display("FAIL ar_ack_ignored: flags=%b ir=%h want 000/0000", {imem_req, ir_valid, halted}, ir); n_bad++;
        end
        n_cmp++;
        rst_n = 1'b1; imem_ack = 1'b0; en = 1'b0;
        step();
        if ({imem_req, ir_valid, halted} !== 3'b000) begin
            $display("FAIL ar_idle: flags=%b want 000", {imem_req, ir_valid, halted}); n_bad++;
        end
        n_cmp++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_back_to_back();
        test_redirect_ready();
        test_wrap();
        test_squash();
        test_redirect_ack();
        test_idle_redirect();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
